instr_fetch_pc: RTL and testbench

Program-counter and fetch sequencer that drives the byte `address` into the instruction ROM/decoder. It tracks the ROM's two-cycle fetch/decode latency and tags each decoded instruction with its PC and a valid flag. It applies stall and branch-redirect requests from execute and squashes wrong-path fetches. It sits directly upstream of the ROM; its `pc_tag`/`instr_valid` outputs travel alongside the ROM's `rs1`/`rs2`/`rd`/`imm`/`contentout` into the register-read stage.

---
 rtl/instr_fetch_pc.sv | 102 ++++++++++
 tb/tb_instr_fetch_pc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_pc.sv
// PC / fetch sequencer in front of the two-cycle instruction ROM; tags decode outputs with PC and valid.
// Optional halt-on-zero-word behaviour is built only when INSTR_FETCH_HALT_EN is defined.
module instr_fetch_pc #(
  parameter logic [7:0] RESET_PC = 8'd4,
  parameter logic [7:0] PC_STEP  = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_pc,
  input  logic [11:0] branch_imm,
  input  logic [31:0] instr_in,
  output logic [7:0]  address,
  output logic [7:0]  pc_tag,
  output logic        instr_valid,
  output logic        halted,
  output logic        fsm_state
);

  // Handshake: none. stall and branch_taken are single-cycle level requests
  // sampled every rising edge; branch_taken wins over stall in the same cycle.

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_d;
  logic        issue;
  logic        squash;
  logic        s0_v, s1_v;
  logic [7:0]  s0_pc, s1_pc;
  logic [7:0]  br_target;
  logic        unused_bits;

  // Only the low 8 bits of the sign-extended offset survive the modulo-256 add.
  assign br_target = branch_pc + {branch_imm[6:0], 1'b0};

`ifdef INSTR_FETCH_HALT_EN
  logic halt_hit;
  assign halt_hit    = instr_valid && (instr_in == 32'h0);
  assign unused_bits = ^branch_imm[11:7];
`else
  assign unused_bits = ^{branch_imm[11:7], instr_in};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = address;
    issue   = 1'b0;
    squash  = 1'b0;
    case (state_q)
      RUN: begin
`ifdef INSTR_FETCH_HALT_EN
        // The zero word halts fetch; younger fetches behind it are discarded.
        if (halt_hit) begin
          state_d = HALT;
          squash  = 1'b1;
        end else
`endif
        if (branch_taken) begin
          addr_d = br_target;
          squash = 1'b1;
        end else if (!stall) begin
          addr_d = address + PC_STEP;
          issue  = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      address <= RESET_PC;
      s0_v    <= 1'b0;
      s0_pc   <= 8'd0;
      s1_v    <= 1'b0;
      s1_pc   <= 8'd0;
    end else begin
      state_q <= state_d;
      address <= addr_d;
      s0_v    <= issue;
      s0_pc   <= address;
      s1_v    <= s0_v & ~squash;
      s1_pc   <= s0_pc;
    end
  end

  assign instr_valid = s1_v;
  assign pc_tag      = s1_pc;
  assign fsm_state   = state_q;

`ifdef INSTR_FETCH_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_pc.sv
// Self-checking bench for instr_fetch_pc: directed scenarios then random stall/branch/reset traffic
// compared against a cycle-indexed fetch history model.
module tb_instr_fetch_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_pc = 8'd0;
  logic [11:0] branch_imm = 12'd0;
  logic [31:0] instr_in = 32'h13;
  logic [7:0]  address;
  logic [7:0]  pc_tag;
  logic        instr_valid;
  logic        halted;
  logic        fsm_state;

  instr_fetch_pc dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_imm(branch_imm), .instr_in(instr_in),
    .address(address), .pc_tag(pc_tag), .instr_valid(instr_valid),
    .halted(halted), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: what happened in each cycle n (inputs sampled at the edge ending cycle n).
  int  n = 0;
  int  mpc = 4;
  bit  model_ok = 1'b0;
  bit  issued [0:4095];
  bit  kill   [0:4095];
  bit  rst_at [0:4095];
  int  ipc    [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  function automatic int target(input int bp, input logic [11:0] bi);
    int off;
    off = int'({bi, 1'b0});
    if (off >= 4096) off = off - 8192;
    return ((bp + off) % 256 + 256) % 256;
  endfunction

  function automatic bit exp_valid();
    if (n < 2) return 1'b0;
    return issued[n-2] && !kill[n-1];
  endfunction

  task automatic check_outputs();
    if (!model_ok) return;
    chk("address", {24'd0, address}, mpc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid()});
    if (exp_valid())
      chk("pc_tag", {24'd0, pc_tag}, ipc[n-2]);
    else if (rst_at[n-1] || (n >= 2 && rst_at[n-2]))
      chk("pc_tag_reset", {24'd0, pc_tag}, 32'd0);
    chk("halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic do_cycle(input bit r, input bit s, input bit b,
                          input logic [7:0] bp, input logic [11:0] bi);
    int nxt;
    check_outputs();
    rst = r; stall = s; branch_taken = b; branch_pc = bp; branch_imm = bi;
    ipc[n] = mpc;
    if (r) begin
      nxt = 4; kill[n] = 1'b1; rst_at[n] = 1'b1;
    end else if (b) begin
      nxt = target(bp, bi); kill[n] = 1'b1;
    end else if (s) begin
      nxt = mpc;
    end else begin
      issued[n] = 1'b1; nxt = (mpc + 4) % 256;
    end
    @(posedge clk); #1;
    if (r) model_ok = 1'b1;
    mpc = nxt;
    n++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) do_cycle(0, 0, 0, 8'd0, 12'd0);
  endtask

  task automatic run_until(input int pc);
    int guard = 0;
    while (mpc != pc && guard < 200) begin
      do_cycle(0, 0, 0, 8'd0, 12'd0);
      guard++;
    end
    chk("reach_pc", mpc, pc);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      issued[i] = 0; kill[i] = 0; rst_at[i] = 0; ipc[i] = 0;
    end
    @(posedge clk); #1;

    // Reset, then sequential fetch 4, 8, 12...
    do_cycle(1, 0, 0, 8'd0, 12'd0);
    do_cycle(1, 0, 0, 8'd0, 12'd0);
    run(6);

    // Stall three cycles at address 20.
    run_until(20);
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 8'd0, 12'd0);
    run(5);

    // Forward branch 92 + 24 -> 116.
    do_cycle(0, 0, 1, 8'd92, 12'h00C);
    run(4);

    // Branch and stall together, backward offset: 92 - 4 -> 88.
    do_cycle(0, 1, 1, 8'd92, 12'hFFE);
    run(4);

    // Jump near the top of the address space and wrap 252 -> 0.
    do_cycle(0, 0, 1, 8'd240, 12'h002);
    run(7);

    // Mid-stream reset at address 48.
    run_until(48);
    do_cycle(1, 0, 0, 8'd0, 12'd0);
    run(5);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      int roll;
      bit r, s, b;
      roll = $urandom_range(0, 99);
      r = (roll < 2);
      b = (roll >= 2 && roll < 12) || ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 4) == 0);
      instr_in = $urandom | 32'h1;
      do_cycle(r, s, b, 8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)));
    end
    run(3);

`ifdef INSTR_FETCH_HALT_EN
    begin
      int frz;
      bit found;
      found = 0;
      frz = 0;
      instr_in = 32'h13;
      do_cycle(1, 0, 0, 8'd0, 12'd0);
      for (int i = 0; i < 60 && !found; i++) begin
        if (exp_valid() && ipc[n-2] == 96) begin
          instr_in = 32'h0;
          frz = mpc;
          found = 1;
        end else begin
          instr_in = 32'h13;
        end
        do_cycle(0, 0, 0, 8'd0, 12'd0);
      end
      chk("halt_zero_seen", {31'd0, found}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_addr_frozen", {24'd0, address}, frz);
        chk("halt_valid_low", {31'd0, instr_valid}, 32'd0);
        rst = 0; stall = i[0]; branch_taken = 1'b1; branch_pc = 8'd8; branch_imm = 12'h010;
        @(posedge clk); #1;
        n++;
      end
      branch_taken = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
